mc_core: RTL
============

Name: mc_core

Overview:
- Parametrised multi-cycle successor to the single-cycle 9-bit processor top.
- Same 9-bit instruction encoding, 8-entry register file and zero flag as the single-cycle top.
- Generalised data width and program depth.
- Adds a start/Done run control and a variable-latency req/ack data-memory handshake.
- Instruction ROM and data memory are external; the core drives their addresses.

Parameters:
- DW, 8, datapath/register/data-address width (4..32).
- PW, 6, program counter width; program depth 2**PW.
- NREG, 8, register count; fixed at 8 because register fields are 3 bits. Only legal value.

Ports:
- Clk  in  1  clock
- Reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; begins execution at PC=0
- imem_addr  out  PW  instruction address (combinational from PC)
- imem_data  in  9  instruction word; valid in the same cycle as imem_addr
- dmem_req  out  1  data-memory request, held until ack
- dmem_we  out  1  1=store, 0=load; stable while req
- dmem_addr  out  DW  data address; stable while req
- dmem_wdata  out  DW  store data; stable while req
- dmem_rdata  in  DW  load data; sampled when ack=1
- dmem_ack  in  1  completes the request in this cycle
- Done  out  1  high in HALT state

Behaviour:
- Reset state: IDLE; PC=0; all registers=0; zero flag=0; dmem_req=0; dmem_we=0; dmem_addr=0; dmem_wdata=0; Done=0.
- Encoding: op=[8:6], rd=[5:3], rs=[2:0], imm6=[5:0].
- op 000 ADD: R[rd]=R[rd]+R[rs], modulo 2**DW.
- op 001 SUB: R[rd]=R[rd]-R[rs], modulo 2**DW.
- op 010 AND.
- op 011 XOR.
- op 100 LDR: R[rd]=mem[R[rs]].
- op 101 STR: mem[R[rs]]=R[rd].
- op 110 BZ: if Z, PC=PC+sext(imm6) (wraps modulo 2**PW); else PC+1.
- op 111 LI: R0=zext(imm6). Exception: imm6=6'h3F is HALT.
- Z is updated by ALU ops (000-011) only; Z=(result==0).
- FSM IDLE: wait for start=1, then PC=0 and go to FETCH.
- FSM FETCH (1 cycle): latch imem_data into IR, go to EXEC.
- FSM EXEC (1 cycle):
  - ALU ops, LI: write back, PC+1, go to FETCH.
  - BZ: update PC, go to FETCH.
  - LDR/STR: drive dmem_*, assert req, go to MEM.
  - HALT: go to HALT; PC unchanged.
- FSM MEM:
  - hold req/we/addr/wdata until dmem_ack=1.
  - On ack: LDR writes dmem_rdata to R[rd]; deassert req the next cycle; PC+1; go to FETCH.
  - ack while req=0 is ignored.
- FSM HALT: Done=1. start restarts at PC=0; registers and Z are retained.
- CPI: 2 for ALU/branch; 3+wait cycles for memory ops, with minimum wait 0 (ack in the first MEM cycle).
- PC increment past 2**PW-1 wraps to 0.
- Addresses use the full DW bits.
- start is ignored in FETCH, EXEC and MEM.
- Reset mid-MEM: req drops immediately (asynchronously); no register write occurs.

Optional Feature:
- Macro MC_CORE_DBG_EN.
- When defined, adds outputs dbg_pc (PW), dbg_state (3), dbg_retire (1).
- dbg_retire pulses for 1 cycle on each instruction completion, including HALT.
- When undefined, these ports do not exist; functional behaviour is identical.

Decomposition:
- Package mc_core_pkg holds:
  - opcode enum (OP_ADD..OP_SPC);
  - state enum (S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALT);
  - HALT_IMM=6'h3F.
- One sub-module: mc_alu, combinational, parametrised DW; outputs result and zero.
- Register file stays inline as an 8xDW array with async reset.

Test Plan:
- Program: LI 5; ADD r1,r0; ADD r1,r0; HALT, then start -> R1=10, Done=1 after 8 cycles from start, Z=0.
- LI 3; SUB r0,r0; BZ +2; LI 7; HALT -> BZ taken, R0 stays 0, LI 7 skipped, Done=1.
- STR r0,r1 with R0=0x2A, R1=0x10; ack delayed 3 cycles -> req held 4 cycles, addr=0x10, wdata=0x2A stable, we=1.
- LDR r2,r1 with ack in the first MEM cycle, rdata=0x5C -> R2=0x5C; instruction takes 3 cycles.
- Reset asserted during MEM wait -> dmem_req=0 immediately, all registers 0, state IDLE; start re-runs from PC=0.
- DW=16, PW=4: BZ -8 from PC=2 -> PC wraps to 10. Also 0xFFFF+1 -> 0 with Z=1.

Source files
------------

// File: rtl/mc_core_pkg.sv
// Shared types and constants for the mc_core multi-cycle 9-bit processor.
package mc_core_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_LDR = 3'b100,
    OP_STR = 3'b101,
    OP_BZ  = 3'b110,
    OP_SPC = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  // Instruction word; imm6 is {rd, rs}
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
  } instr_t;

  localparam logic [5:0] HALT_IMM = 6'h3F;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for mc_core: ADD/SUB/AND/XOR with zero detect.
module mc_alu #(
  parameter int unsigned DW = 8
) (
  input  logic [1:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          zero
);

  always_comb begin
    case (op)
      2'b00:   result = a + b;
      2'b01:   result = a - b;
      2'b10:   result = a & b;
      default: result = a ^ b;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/mc_core.sv
// Multi-cycle 9-bit processor core with start/Done control and req/ack data memory.
// Optional debug ports enabled by defining MC_CORE_DBG_EN.
module mc_core
  import mc_core_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned PW   = 6,
  parameter int unsigned NREG = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          start,
  output logic [PW-1:0] imem_addr,
  input  logic [8:0]    imem_data,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ack,
  output logic          Done
`ifdef MC_CORE_DBG_EN
  ,
  output logic [PW-1:0] dbg_pc,
  output logic [2:0]    dbg_state,
  output logic          dbg_retire
`endif
);

  localparam int unsigned BW = (PW > 6) ? PW : 6;

  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d;
  instr_t        ir_q, ir_d;
  logic          z_q, z_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          done_q, done_d;

  logic [DW-1:0] regs [NREG];
  logic          rf_we;
  logic [2:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  logic [DW-1:0] alu_res;
  logic          alu_zero;
  logic [5:0]    imm6;
  logic [BW-1:0] br_off;
  logic [PW-1:0] pc_inc;
  logic [PW-1:0] pc_br;

  mc_alu #(.DW(DW)) u_alu (
    .op     (ir_q.op[1:0]),
    .a      (regs[ir_q.rd]),
    .b      (regs[ir_q.rs]),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Branch offset is sign-extended to at least 6 bits, then wrapped to PW
  assign imm6   = {ir_q.rd, ir_q.rs};
  assign br_off = BW'($signed(imm6));
  assign pc_inc = pc_q + PW'(1);
  assign pc_br  = pc_q + PW'(br_off);

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_d      = z_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rf_we    = 1'b0;
    rf_waddr = ir_q.rd;
    rf_wdata = alu_res;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = imem_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q.op)
          OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
            rf_we = 1'b1;
            z_d   = alu_zero;
            pc_d  = pc_inc;
          end
          OP_LDR, OP_STR: begin
            req_d   = 1'b1;
            we_d    = (ir_q.op == OP_STR);
            addr_d  = regs[ir_q.rs];
            wdata_d = regs[ir_q.rd];
            state_d = S_MEM;
          end
          OP_BZ: begin
            pc_d = z_q ? pc_br : pc_inc;
          end
          OP_SPC: begin
            if (imm6 == HALT_IMM) begin
              state_d = S_HALT;
            end else begin
              rf_we    = 1'b1;
              rf_waddr = 3'd0;
              rf_wdata = DW'(imm6);
              pc_d     = pc_inc;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (dmem_ack && req_q) begin
          req_d    = 1'b0;
          rf_we    = !we_q;
          rf_wdata = dmem_rdata;
          pc_d     = pc_inc;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_HALT);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  // Register file
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  assign imem_addr  = pc_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign Done       = done_q;

`ifdef MC_CORE_DBG_EN
  logic retire_c;
  logic retire_q;

  // An instruction completes at the end of EXEC (non-memory ops, HALT) or on MEM ack
  assign retire_c = ((state_q == S_EXEC) && (ir_q.op != OP_LDR) && (ir_q.op != OP_STR)) ||
                    ((state_q == S_MEM) && dmem_ack && req_q);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      retire_q <= 1'b0;
    end else begin
      retire_q <= retire_c;
    end
  end

  assign dbg_pc     = pc_q;
  assign dbg_state  = state_q;
  assign dbg_retire = retire_q;
`endif

endmodule
